i2s_sample_tx: RTL and testbench
================================

Name: i2s_sample_tx

Overview:
- Output-side transmitter for the synth audio path.
- Accepts 16-bit mono samples from the echo stage on a single-cycle `in_ready` strobe and buffers them in a 4-entry FIFO.
- Serializes each sample MSB-first onto a left-justified I2S-style stereo link (BCLK/LRCLK/SDATA) for the DAC; the same sample goes on both channels.
- Sits between echo output (`out`/`out_ready`) and the board DAC pins.

Parameters:
- BCLK_DIV, 4: clk cycles per BCLK half-period. Legal range 1..255.
- FIFO_DEPTH, 4: sample FIFO entries. Power of two, at least 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sample_in  input  16  two's-complement sample; valid when in_ready=1.
- in_ready  input  1  one-cycle write strobe.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- overflow  output  1  one-cycle pulse: write attempted while full, sample dropped.
- underflow  output  1  one-cycle pulse: frame started with FIFO empty.
- frame_start  output  1  one-cycle pulse on the cycle a new frame is loaded.
- bclk  output  1  bit clock.
- lrclk  output  1  0 = left, 1 = right.
- sdata  output  1  serial data.

Behaviour:
- Reset values: bclk=0, lrclk=0, sdata=0, full=0, overflow=0, underflow=0, frame_start=0. Internally: FIFO empty, div_cnt=0, bit_cnt=31, shift sample=0.
- Reset asserted mid-frame: all state returns to reset values on the next clk edge and any FIFO contents are discarded.
- All outputs are registered.

Divider:
- div_cnt counts 0..BCLK_DIV-1.
- When div_cnt==BCLK_DIV-1, bclk toggles and div_cnt returns to 0.
- BCLK period is 2*BCLK_DIV clk cycles.
- The first falling edge of bclk after reset occurs at clk edge 2*BCLK_DIV.

Falling-edge event (the clk cycle on which bclk goes 1->0):
- bit_cnt increments mod 32; 31 -> 0 is a frame boundary.
- lrclk takes the new bit_cnt[4].
- sdata takes sample_reg[15 - new bit_cnt[3:0]].
- Bits 0-15: left channel. Bits 16-31: right channel. Both carry the same sample, MSB first.
- Data changes on the bclk falling edge; the DAC samples on the rising edge.

Frame boundary:
- FIFO non-empty: pop the head into sample_reg. sdata takes that sample's bit 15 in the same cycle (load bypasses into sdata), and frame_start pulses.
- FIFO empty: sample_reg is loaded with 0, underflow pulses, and frame_start still pulses.
- Because bit_cnt resets to 31, the first frame boundary is the first falling edge after reset.

FIFO:
- Write on in_ready when not full.
- Write while full: sample dropped, overflow pulses, contents unchanged.
- Write and pop in the same cycle while full: the pop frees an entry, so the write is accepted, count stays FIFO_DEPTH, and overflow does not pulse.
- Write and pop in the same cycle while empty: no bypass; zero is transmitted, underflow pulses, and the write is stored (count=1).
- full is registered and reflects the count after the current cycle's pop/write.
- Pointers wrap modulo FIFO_DEPTH. The count is one bit wider than the pointers so full and empty are distinguishable.

Timing:
- One frame is 32 bclk periods = 64*BCLK_DIV clk cycles; fs = f_clk / (64*BCLK_DIV).
- Sample-to-pin latency runs from the write to the next frame boundary at which that sample is at the FIFO head.

Test Plan:
- Reset/idle (BCLK_DIV=2): hold reset 4 cycles, then release with no writes -> bclk toggles every 2 clk cycles; the first falling edge is at cycle 4 and raises frame_start and underflow. sdata stays 0, and lrclk goes 1 at bit 16 and 0 at bit 0.
- Single sample: write 16'hA5C3 before the first frame boundary -> sdata on successive falling edges is 1010010111000011 with lrclk=0, then the same 16 bits with lrclk=1; the next frame sends zeros with underflow.
- Overflow: write 5 samples 1,2,3,4,5 on consecutive cycles with no frame boundary in between -> full=1 after the 4th write; overflow pulses on the 5th; frames then carry 1,2,3,4, then 0 with underflow.
- Full plus simultaneous pop: fill to 4, then strobe in_ready with 16'h7FFF on the frame_start cycle -> accepted, no overflow, full stays 1, and 16'h7FFF is transmitted 4 frames later.
- Empty plus simultaneous write: strobe 16'h8000 exactly on a frame-boundary cycle with the FIFO empty -> that frame is zeros with underflow; the next frame carries 8000 (MSB 1, then fifteen 0s).
- Reset mid-frame: assert reset at bit 9 of a frame with 2 samples queued -> next cycle all outputs are 0; after release, the first frame carries zeros with underflow, confirming the queued samples were discarded.

Source files
------------

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: buffers 16-bit mono samples in a small FIFO and serializes
// each one MSB-first onto a left-justified stereo link (BCLK/LRCLK/SDATA).
// The same sample is sent on the left (bits 0-15) and right (bits 16-31)
// halves of every 32-bit frame. Data changes on the bclk falling edge so
// the DAC can sample on the rising edge.
//
// Input handshake: in_ready is a one-cycle write strobe with no back-pressure.
// A strobe is accepted when the FIFO has room after this cycle's pop; if it
// is not accepted, the sample is dropped and overflow pulses for one cycle.
// full tells the producer ahead of time that the next strobe would be lost
// unless a frame boundary pops an entry in the same cycle.
module i2s_sample_tx #(
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        in_ready,
  output logic        full,
  output logic        overflow,
  output logic        underflow,
  output logic        frame_start,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [7:0]       DIV_LAST = 8'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Divider / bit clock state
  logic [7:0]       div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  // Frame serializer state
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      sample_q, sample_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  // FIFO bookkeeping
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  // Registered event pulses
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             frame_start_q, frame_start_d;
  // FIFO storage (no reset needed: pointers and count define validity)
  logic [15:0]      mem_q [FIFO_DEPTH];

  // Internal events
  logic             div_tick;
  logic             fall_evt;
  logic [4:0]       bit_cnt_nxt;
  logic             boundary;
  logic             fifo_empty;
  logic             pop;
  logic             wr_accept;
  logic [15:0]      head;

  // Divider: bclk toggles every BCLK_DIV clk cycles; the 1->0 toggle is the
  // falling-edge event that advances the serializer.
  always_comb begin
    div_tick  = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_tick ? 8'd0 : div_cnt_q + 8'd1;
    bclk_d    = div_tick ? ~bclk_q : bclk_q;
    fall_evt  = div_tick & bclk_q;
  end

  // FIFO control: a frame boundary pops first, so a write in the same cycle
  // sees the freed entry; with an empty FIFO the write is simply stored.
  always_comb begin
    bit_cnt_nxt = bit_cnt_q + 5'd1;
    boundary    = fall_evt & (bit_cnt_nxt == 5'd0);
    fifo_empty  = (count_q == '0);
    pop         = boundary & ~fifo_empty;
    head        = mem_q[rd_ptr_q];
    wr_accept   = in_ready & ((count_q != CNT_FULL) | pop);

    wr_ptr_d    = wr_accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d     = count_q;
    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d      = (count_d == CNT_FULL);
    overflow_d  = in_ready & ~wr_accept;
  end

  // Serializer: on each falling event advance the bit index; at the frame
  // boundary load the next sample (or silence) and bypass its MSB to sdata.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    sample_d      = sample_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    underflow_d   = 1'b0;
    frame_start_d = 1'b0;
    if (fall_evt) begin
      bit_cnt_d = bit_cnt_nxt;
      if (boundary) begin
        frame_start_d = 1'b1;
        if (fifo_empty) begin
          sample_d    = 16'd0;
          underflow_d = 1'b1;
        end else begin
          sample_d    = head;
        end
      end
      lrclk_d = bit_cnt_nxt[4];
      sdata_d = sample_d[4'd15 - bit_cnt_nxt[3:0]];
    end
  end

  // State registers with synchronous reset; reset also discards FIFO contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= 8'd0;
      bclk_q        <= 1'b0;
      bit_cnt_q     <= 5'd31;
      sample_q      <= 16'd0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      bit_cnt_q     <= bit_cnt_d;
      sample_q      <= sample_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      frame_start_q <= frame_start_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign full        = full_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign frame_start = frame_start_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign sdata       = sdata_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb_i2s_sample_tx: directed bench for i2s_sample_tx with a frame-level
// reference model checked every cycle, plus literal frame expectations.
module tb_i2s_sample_tx;

  localparam int BD    = 2;
  localparam int DEPTH = 4;

  // Clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = 16'd0;
  logic        in_ready = 1'b0;
  logic        full, overflow, underflow, frame_start, bclk, lrclk, sdata;

  always #5 clk = ~clk;

  i2s_sample_tx #(.BCLK_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .in_ready(in_ready),
    .full(full), .overflow(overflow), .underflow(underflow),
    .frame_start(frame_start), .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bclk phase, bit index and frame contents follow from
  // the number of clk edges since reset; the FIFO is a plain queue.
  int          k;
  int          bitn;
  logic        m_valid = 1'b0;
  logic        e_bclk, e_lr, e_sd, e_full, e_ovf, e_udf, e_fs;
  logic [15:0] cur;
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      k = 0; cur = 16'd0; exp_q.delete();
      e_bclk = 0; e_lr = 0; e_sd = 0; e_full = 0; e_ovf = 0; e_udf = 0; e_fs = 0;
      m_valid = 1'b1;
    end else begin
      k++;
      e_ovf = 0; e_udf = 0; e_fs = 0;
      e_bclk = ((k / BD) % 2) == 1;
      if (k % (2 * BD) == 0) begin
        bitn = ((k / (2 * BD)) - 1) % 32;
        if (bitn == 0) begin
          e_fs = 1;
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          else begin cur = 16'd0; e_udf = 1; end
        end
        e_lr = (bitn >= 16);
        e_sd = cur[15 - (bitn % 16)];
      end
      if (in_ready) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(sample_in);
        else e_ovf = 1;
      end
      e_full = (exp_q.size() == DEPTH);
    end
  end

  // Compare process: every output against the model on every falling clk edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("bclk", bclk, e_bclk);
      chk("lrclk", lrclk, e_lr);
      chk("sdata", sdata, e_sd);
      chk("full", full, e_full);
      chk("overflow", overflow, e_ovf);
      chk("underflow", underflow, e_udf);
      chk("frame_start", frame_start, e_fs);
    end
  end

  // Driver helpers
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 300);
    if (frame_start !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_frame_start: got no frame_start within %0d cycles", n);
    end
  endtask

  // Called at the negedge where frame_start is high; collects 32 sdata bits.
  task automatic capture(output logic [31:0] bits);
    logic prev;
    int   g;
    bits = '0;
    bits[31] = sdata;
    chk("lrclk_bit0", lrclk, 0);
    for (int i = 1; i < 32; i++) begin
      g = 0;
      do begin
        prev = bclk;
        @(negedge clk);
        g++;
      end while (!(prev === 1'b1 && bclk === 1'b0) && g < 20);
      if (!(prev === 1'b1 && bclk === 1'b0)) begin
        checks++; errors++;
        $display("FAIL capture_timeout: no bclk fall for bit %0d", i);
      end
      bits[31 - i] = sdata;
      chk("lrclk_frame", lrclk, (i >= 16));
    end
  endtask

  task automatic write1(input logic [15:0] v);
    sample_in = v;
    in_ready  = 1'b1;
    @(negedge clk);
    in_ready  = 1'b0;
  endtask

  logic [31:0] bits;
  int          n;
  logic [15:0] exp_vals[5];

  initial begin
    // Reset / idle
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_full", full, 0);
    chk("rst_frame_start", frame_start, 0);
    reset = 1'b0;
    wait_fs(n);
    chk("first_fs_cycle", n, 2 * BD);
    chk("first_underflow", underflow, 1);
    capture(bits);
    chk("idle_frame", bits, 32'h0);

    // Single sample
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    write1(16'hA5C3);
    wait_fs(n);
    chk("fs_after_write", n, 2 * BD - 1);
    chk("single_no_underflow", underflow, 0);
    capture(bits);
    chk("single_frame", bits, 32'hA5C3A5C3);
    wait_fs(n);
    chk("single_next_underflow", underflow, 1);
    capture(bits);
    chk("single_next_zero", bits, 32'h0);

    // Overflow
    wait_fs(n);
    for (int i = 1; i <= 5; i++) begin
      sample_in = 16'(i);
      in_ready  = 1'b1;
      @(negedge clk);
      if (i == 4) begin
        chk("ovf_full_after4", full, 1);
        chk("ovf_none_on4", overflow, 0);
      end
      if (i == 5) chk("ovf_pulse_on5", overflow, 1);
    end
    in_ready = 1'b0;
    @(negedge clk);
    chk("ovf_pulse_ends", overflow, 0);
    exp_vals = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
    for (int i = 0; i < 5; i++) begin
      wait_fs(n);
      chk("ovf_frame_underflow", underflow, (exp_vals[i] == 16'd0));
      capture(bits);
      chk("ovf_frame", bits, {exp_vals[i], exp_vals[i]});
    end

    // Full plus simultaneous pop on the boundary edge
    wait_fs(n);
    for (int i = 0; i < 4; i++) begin
      sample_in = 16'(11 + i);
      in_ready  = 1'b1;
      @(negedge clk);
    end
    in_ready = 1'b0;
    chk("fill_full", full, 1);
    repeat (123) @(negedge clk);
    write1(16'h7FFF);
    chk("pop_write_boundary", frame_start, 1);
    chk("pop_write_no_ovf", overflow, 0);
    chk("pop_write_full", full, 1);
    exp_vals = '{16'd12, 16'd13, 16'd14, 16'h7FFF, 16'd0};
    for (int i = 0; i < 4; i++) begin
      wait_fs(n);
      capture(bits);
      chk("full_pop_frame", bits, {exp_vals[i], exp_vals[i]});
    end

    // Empty plus simultaneous write on the boundary edge
    wait_fs(n);
    repeat (127) @(negedge clk);
    write1(16'h8000);
    chk("empty_write_boundary", frame_start, 1);
    chk("empty_write_underflow", underflow, 1);
    capture(bits);
    chk("empty_write_zero_frame", bits, 32'h0);
    wait_fs(n);
    chk("empty_write_next_no_udf", underflow, 0);
    capture(bits);
    chk("empty_write_next_frame", bits, 32'h80008000);

    // Reset mid-frame with two samples queued
    wait_fs(n);
    write1(16'hAAAA);
    write1(16'hBBBB);
    repeat (34) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_bclk", bclk, 0);
    chk("midrst_lrclk", lrclk, 0);
    chk("midrst_sdata", sdata, 0);
    chk("midrst_full", full, 0);
    chk("midrst_underflow", underflow, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_fs(n);
    chk("midrst_fs_cycle", n, 2 * BD);
    chk("midrst_underflow_after", underflow, 1);
    capture(bits);
    chk("midrst_discarded", bits, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
